l2_tlb_refill_ctrl: RTL and testbench

L2_TLB_REFILL_CTRL -- requirements
Module: L2_tlb_refill_ctrl

---
 rtl/l2_tlb_refill_ctrl.sv | 95 +++++++++
 tb/tb_l2_tlb_refill_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_tlb_refill_ctrl.sv
// rtl/l2_tlb_refill_ctrl.sv - L2 TLB miss capture and page-table-walk refill sequencer
// Optional miss counter port and logic enabled by defining L2_TLB_PERF_CNT_EN.
module l2_tlb_refill_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    input  logic [6:0]  io_req_bits_asid,
    input  logic [26:0] io_req_bits_vpn,
    input  logic        io_req_bits_instruction,
    input  logic        io_req_bits_store,
    input  logic        io_lookup_hit,
    input  logic        io_ptw_req_ready,
    input  logic        io_ptw_resp_valid,
    input  logic [19:0] io_ptw_resp_bits_ppn,
    input  logic        io_ptw_invalidate,
    output logic [1:0]  state,
    output logic [33:0] r_refill_asid_vpn,
    output logic        r_req_instruction,
    output logic        r_req_store,
    output logic        refill_valid,
    output logic [33:0] refill_tag,
    output logic [19:0] refill_ppn
`ifdef L2_TLB_PERF_CNT_EN
    ,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT     = 2'd2,
        WAIT_INV = 2'd3
    } state_t;

    state_t st;

    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st                <= IDLE;
            r_refill_asid_vpn <= '0;
            r_req_instruction <= 1'b0;
            r_req_store       <= 1'b0;
            refill_valid      <= 1'b0;
            refill_tag        <= '0;
            refill_ppn        <= '0;
`ifdef L2_TLB_PERF_CNT_EN
            miss_count        <= '0;
`endif
        end else begin
            refill_valid <= 1'b0;
            case (st)
                IDLE: begin
                    if (io_req_valid && !io_lookup_hit) begin
                        r_refill_asid_vpn <= {io_req_bits_asid, io_req_bits_vpn};
                        r_req_instruction <= io_req_bits_instruction;
                        r_req_store       <= io_req_bits_store;
`ifdef L2_TLB_PERF_CNT_EN
                        miss_count        <= miss_count + 32'd1;
`endif
                        st                <= REQUEST;
                    end
                end
                REQUEST: begin
                    // An invalidate before the walker took the request drops it;
                    // after acceptance the walk must still drain its response.
                    if (io_ptw_invalidate) begin
                        st <= io_ptw_req_ready ? WAIT_INV : IDLE;
                    end else if (io_ptw_req_ready) begin
                        st <= WAIT;
                    end
                end
                WAIT: begin
                    if (io_ptw_resp_valid) begin
                        refill_valid <= 1'b1;
                        refill_tag   <= r_refill_asid_vpn;
                        refill_ppn   <= io_ptw_resp_bits_ppn;
                        st           <= IDLE;
                    end else if (io_ptw_invalidate) begin
                        st <= WAIT_INV;
                    end
                end
                WAIT_INV: begin
                    if (io_ptw_resp_valid) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_tlb_refill_ctrl.sv
// tb/tb_l2_tlb_refill_ctrl.sv - scoreboard bench for l2_tlb_refill_ctrl
module tb_l2_tlb_refill_ctrl;

    logic        clk;
    logic        reset;
    logic        io_req_valid;
    logic [6:0]  io_req_bits_asid;
    logic [26:0] io_req_bits_vpn;
    logic        io_req_bits_instruction;
    logic        io_req_bits_store;
    logic        io_lookup_hit;
    logic        io_ptw_req_ready;
    logic        io_ptw_resp_valid;
    logic [19:0] io_ptw_resp_bits_ppn;
    logic        io_ptw_invalidate;
    logic [1:0]  state;
    logic [33:0] r_refill_asid_vpn;
    logic        r_req_instruction;
    logic        r_req_store;
    logic        refill_valid;
    logic [33:0] refill_tag;
    logic [19:0] refill_ppn;
`ifdef L2_TLB_PERF_CNT_EN
    logic [31:0] miss_count;
`endif

    l2_tlb_refill_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .io_req_valid            (io_req_valid),
        .io_req_bits_asid        (io_req_bits_asid),
        .io_req_bits_vpn         (io_req_bits_vpn),
        .io_req_bits_instruction (io_req_bits_instruction),
        .io_req_bits_store       (io_req_bits_store),
        .io_lookup_hit           (io_lookup_hit),
        .io_ptw_req_ready        (io_ptw_req_ready),
        .io_ptw_resp_valid       (io_ptw_resp_valid),
        .io_ptw_resp_bits_ppn    (io_ptw_resp_bits_ppn),
        .io_ptw_invalidate       (io_ptw_invalidate),
        .state                   (state),
        .r_refill_asid_vpn       (r_refill_asid_vpn),
        .r_req_instruction       (r_req_instruction),
        .r_req_store             (r_req_store),
        .refill_valid            (refill_valid),
        .refill_tag              (refill_tag),
        .refill_ppn              (refill_ppn)
`ifdef L2_TLB_PERF_CNT_EN
        ,
        .miss_count              (miss_count)
`endif
    );

    typedef struct {
        int          cyc;
        logic [33:0] tag;
        logic [19:0] ppn;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    logic [33:0] last_tag;
    logic [33:0] last_refill_tag;
    logic [31:0] misses;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every refill pulse must match the oldest scoreboard entry, in its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (refill_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_refill", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("refill_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("refill_tag", 64'(refill_tag), 64'(mon_e.tag));
                    check("refill_ppn", 64'(refill_ppn), 64'(mon_e.ppn));
                    last_refill_tag = mon_e.tag;
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check("missing_refill", 64'd0, 64'd1);
                mon_e = sb_q.pop_front();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        io_req_valid            = 1'b0;
        io_req_bits_asid        = '0;
        io_req_bits_vpn         = '0;
        io_req_bits_instruction = 1'b0;
        io_req_bits_store       = 1'b0;
        io_lookup_hit           = 1'b0;
        io_ptw_req_ready        = 1'b0;
        io_ptw_resp_valid       = 1'b0;
        io_ptw_resp_bits_ppn    = '0;
        io_ptw_invalidate       = 1'b0;
    endtask

    // Noise on the request side while the controller is busy; it must be ignored.
    task automatic garbage();
        io_req_valid            = 1'($urandom_range(0, 1));
        io_req_bits_asid        = 7'($urandom);
        io_req_bits_vpn         = 27'($urandom);
        io_req_bits_instruction = 1'($urandom_range(0, 1));
        io_req_bits_store       = 1'($urandom_range(0, 1));
        io_lookup_hit           = 1'($urandom_range(0, 1));
        io_ptw_req_ready        = 1'($urandom_range(0, 1));
        io_ptw_resp_valid       = 1'b0;
        io_ptw_resp_bits_ppn    = 20'($urandom);
        io_ptw_invalidate       = 1'b0;
    endtask

    // mode: 0 plain walk, 1 invalidate in REQUEST without ready, 2 invalidate in
    // REQUEST with ready, 3 invalidate during WAIT, 4 response and invalidate together.
    task automatic do_txn(input logic [6:0] asid, input logic [26:0] vpn, input logic ins,
                          input logic st, input logic hit, input int mode, input int stall,
                          input int lat, input logic [19:0] ppn);
        int          c0;
        logic [33:0] tag;
        exp_t        e;
        tag = {asid, vpn};
        idle_in();
        io_req_valid            = 1'b1;
        io_req_bits_asid        = asid;
        io_req_bits_vpn         = vpn;
        io_req_bits_instruction = ins;
        io_req_bits_store       = st;
        io_lookup_hit           = hit;
        c0 = cyc;
        step();
        idle_in();
        if (hit) begin
            check("hit_state", 64'(state), 64'd0);
            check("hit_tag_hold", 64'(r_refill_asid_vpn), 64'(last_tag));
            check("hit_no_refill", 64'(refill_valid), 64'd0);
            return;
        end
        last_tag = tag;
        misses   = misses + 32'd1;
        check("miss_state", 64'(state), 64'd1);
        check("miss_tag", 64'(r_refill_asid_vpn), 64'(tag));
        check("miss_flags", 64'({r_req_instruction, r_req_store}), 64'({ins, st}));
        if (mode == 0 || mode == 4) begin
            e.cyc = c0 + 3 + stall + lat;
            e.tag = tag;
            e.ppn = ppn;
            sb_q.push_back(e);
        end
        for (int i = 0; i < stall; i++) begin
            garbage();
            io_ptw_req_ready  = 1'b0;
            io_ptw_resp_valid = 1'($urandom_range(0, 1));
            step();
        end
        garbage();
        if (mode == 1) begin
            io_ptw_req_ready  = 1'b0;
            io_ptw_invalidate = 1'b1;
            step();
            idle_in();
            check("drop_state", 64'(state), 64'd0);
            io_ptw_resp_valid    = 1'b1;
            io_ptw_resp_bits_ppn = ppn;
            step();
            idle_in();
            check("stray_state", 64'(state), 64'd0);
        end else begin
            io_ptw_req_ready  = 1'b1;
            io_ptw_invalidate = (mode == 2);
            step();
            check("issue_state", 64'(state), (mode == 2) ? 64'd3 : 64'd2);
            for (int i = 0; i < lat; i++) begin
                garbage();
                if (mode == 2) io_ptw_invalidate = 1'($urandom_range(0, 1));
                step();
            end
            if (mode == 3) begin
                garbage();
                io_ptw_invalidate = 1'b1;
                step();
                check("inv_state", 64'(state), 64'd3);
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                    garbage();
                    io_ptw_invalidate = 1'($urandom_range(0, 1));
                    step();
                end
            end
            garbage();
            io_ptw_resp_valid    = 1'b1;
            io_ptw_resp_bits_ppn = ppn;
            io_ptw_invalidate    = (mode == 4);
            step();
            idle_in();
            check("done_state", 64'(state), 64'd0);
        end
        check("tag_held", 64'(r_refill_asid_vpn), 64'(tag));
        if (mode != 0 && mode != 4)
            check("refill_tag_hold", 64'(refill_tag), 64'(last_refill_tag));
`ifdef L2_TLB_PERF_CNT_EN
        check("miss_count", 64'(miss_count), 64'(misses));
`endif
    endtask

    initial begin
        idle_in();
        reset           = 1'b1;
        last_tag        = '0;
        last_refill_tag = '0;
        misses          = '0;
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_r_regs", 64'({r_refill_asid_vpn, r_req_instruction, r_req_store}), 64'd0);
        check("rst_refill", 64'({refill_valid, refill_tag, refill_ppn}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        do_txn(7'h05, 27'h1234567, 1'b0, 1'b1, 1'b0, 0, 0, 2, 20'hABCDE);
        do_txn(7'h11, 27'h7654321, 1'b1, 1'b0, 1'b1, 0, 0, 0, 20'h00000);
        do_txn(7'h22, 27'h0ABCDEF, 1'b1, 1'b0, 1'b0, 3, 1, 1, 20'h12345);
        do_txn(7'h7F, 27'h7FFFFFF, 1'b1, 1'b1, 1'b0, 4, 0, 0, 20'hFFFFF);
        do_txn(7'h00, 27'h0000000, 1'b0, 1'b0, 1'b0, 1, 2, 0, 20'h55555);
        do_txn(7'h3C, 27'h1111111, 1'b0, 1'b1, 1'b0, 2, 0, 3, 20'h0F0F0);

        // Reset landing between edges while a walk is outstanding.
        idle_in();
        io_req_valid     = 1'b1;
        io_req_bits_asid = 7'h2A;
        io_req_bits_vpn  = 27'h0333333;
        step();
        idle_in();
        io_ptw_req_ready = 1'b1;
        step();
        idle_in();
        check("pre_rst_state", 64'(state), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", 64'(state), 64'd0);
        check("async_rst_r_tag", 64'(r_refill_asid_vpn), 64'd0);
        check("async_rst_refill", 64'({refill_valid, refill_tag, refill_ppn}), 64'd0);
        last_tag        = '0;
        last_refill_tag = '0;
        misses          = '0;
        step();
        reset = 1'b0;
        io_ptw_resp_valid    = 1'b1;
        io_ptw_resp_bits_ppn = 20'h77777;
        step();
        idle_in();
        check("post_rst_state", 64'(state), 64'd0);
        check("post_rst_no_refill", 64'(refill_valid), 64'd0);

        for (int t = 0; t < 60; t++) begin
            do_txn(7'($urandom), 27'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), 20'($urandom));
        end

`ifdef L2_TLB_PERF_CNT_EN
        force dut.miss_count = 32'hFFFF_FFFF;
        #1;
        release dut.miss_count;
        misses = 32'hFFFF_FFFF;
        do_txn(7'h01, 27'h0000042, 1'b0, 1'b0, 1'b0, 0, 0, 0, 20'h00042);
        check("miss_count_wrap", 64'(miss_count), 64'd0);
`endif

        repeat (3) step();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
